// File: rtl/posit_div_sched_pkg.sv
// Shared constants and tag type for the two-requester posit divider scheduler.
package posit_div_sched_pkg;
    localparam int DIV_N    = 32;
    localparam int DIV_ES   = 6;
    localparam int DIV_LAT  = 12;
    localparam int DIV_CNTW = 5;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;
endpackage

// File: rtl/posit_div_tagpipe.sv
// Shift register carrying {valid, id} alongside the divider pipeline.
module posit_div_tagpipe
    import posit_div_sched_pkg::*;
#(
    parameter int DEPTH = DIV_LAT + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_id,
    output logic tail_valid,
    output logic tail_id
);
    tag_t [DEPTH-1:0] vld_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[DEPTH-2:0], tag_t'{valid: in_valid, id: in_id}};
    end

    assign tail_valid = vld_pipe[DEPTH-1].valid;
    assign tail_id    = vld_pipe[DEPTH-1].id;
endmodule

// File: rtl/posit_div_sched.sv
// Round-robin sharing of one fixed-latency pipelined posit divider between two
// clients; a tag pipe routes each quotient back to the requester that issued it.
module posit_div_sched
    import posit_div_sched_pkg::*;
#(
    parameter int N    = DIV_N,
    parameter int ES   = DIV_ES,
    parameter int LAT  = DIV_LAT,
    parameter int CNTW = DIV_CNTW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         rsp0_valid,
    output logic [N-1:0] rsp0_q,
    output logic         rsp0_inf,
    output logic         rsp0_zero,
    output logic         rsp1_valid,
    output logic [N-1:0] rsp1_q,
    output logic         rsp1_inf,
    output logic         rsp1_zero,
    output logic [N-1:0] div_in1,
    output logic [N-1:0] div_in2,
    output logic         div_start,
    input  logic [N-1:0] div_out,
    input  logic         div_inf,
    input  logic         div_zero,
    input  logic         div_done,
    output logic         busy,
    output logic         err_done
);
    if (ES >= N || LAT < 1 || LAT + 2 >= (1 << CNTW)) begin : g_bad_cfg
        $error("posit_div_sched: inconsistent N/ES/LAT/CNTW");
    end

    logic            last_grant;
    logic            gnt0, gnt1, xfer;
    logic            tail_valid, tail_id;
    logic [CNTW-1:0] cnt0, cnt1;

    // Ready is masked during reset so nothing is accepted while rst is high.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                if (last_grant == REQ1) gnt0 = 1'b1;
                else                    gnt1 = 1'b1;
            end else if (req0_valid) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign xfer       = gnt0 | gnt1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_in1    <= '0;
            div_in2    <= '0;
            div_start  <= 1'b0;
            last_grant <= REQ1;
        end else if (xfer) begin
            div_in1    <= gnt1 ? req1_a : req0_a;
            div_in2    <= gnt1 ? req1_b : req0_b;
            div_start  <= 1'b1;
            last_grant <= gnt1 ? REQ1 : REQ0;
        end else begin
            div_start  <= 1'b0;
        end
    end

    posit_div_tagpipe #(.DEPTH(LAT + 1)) u_tagpipe (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (xfer),
        .in_id      (gnt1 ? REQ1 : REQ0),
        .tail_valid (tail_valid),
        .tail_id    (tail_id)
    );

    // The tag pipe, not div_done, decides routing; a disagreement is only flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp0_q     <= '0;
            rsp0_inf   <= 1'b0;
            rsp0_zero  <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_q     <= '0;
            rsp1_inf   <= 1'b0;
            rsp1_zero  <= 1'b0;
            err_done   <= 1'b0;
        end else begin
            rsp0_valid <= tail_valid && (tail_id == REQ0);
            rsp1_valid <= tail_valid && (tail_id == REQ1);
            if (tail_valid && tail_id == REQ0) begin
                rsp0_q    <= div_out;
                rsp0_inf  <= div_inf;
                rsp0_zero <= div_zero;
            end
            if (tail_valid && tail_id == REQ1) begin
                rsp1_q    <= div_out;
                rsp1_inf  <= div_inf;
                rsp1_zero <= div_zero;
            end
            if (div_done != tail_valid) err_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (gnt0 && !rsp0_valid)      cnt0 <= cnt0 + CNTW'(1);
            else if (!gnt0 && rsp0_valid) cnt0 <= cnt0 - CNTW'(1);
            if (gnt1 && !rsp1_valid)      cnt1 <= cnt1 + CNTW'(1);
            else if (!gnt1 && rsp1_valid) cnt1 <= cnt1 - CNTW'(1);
        end
    end

    assign busy = (cnt0 != '0) || (cnt1 != '0);
endmodule

// File: doc/posit_div_sched.md
Name: posit_div_sched

Overview:
- Two-requester scheduler that shares one fixed-latency pipelined posit divider (N=32, es=6, 12-stage pipe) between independent clients.
- Round-robin arbitration at one issue per cycle; a tag shift register tracks in-flight requester IDs and routes each quotient back to its owner.
- Sits between client datapaths and the divider core; the divider's own pipeline never stalls.

Parameters:
- N, 32, posit word width
- ES, 6, exponent field width (passed through for configuration consistency only)
- LAT, 12, divider latency, cycles from div_start sample to div_out/div_done valid
- CNTW, 5, width of per-requester outstanding counters (must hold LAT+2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has operands
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a  in  N  requester 0 dividend
- req0_b  in  N  requester 0 divisor
- req1_valid, req1_ready, req1_a, req1_b  as above for requester 1
- rsp0_valid  out  1  one-cycle pulse, result for requester 0
- rsp0_q  out  N  quotient
- rsp0_inf  out  1  NaR/inf flag
- rsp0_zero  out  1  zero flag
- rsp1_valid, rsp1_q, rsp1_inf, rsp1_zero  as above for requester 1
- div_in1  out  N  divider dividend
- div_in2  out  N  divider divisor
- div_start  out  1  issue qualifier to divider
- div_out  in  N  divider quotient
- div_inf  in  1  divider inf flag
- div_zero  in  1  divider zero flag
- div_done  in  1  divider result-valid
- busy  out  1  any request in flight
- err_done  out  1  sticky: div_done disagreed with the tag pipe

Behaviour:
- Reset: every output is 0. Tag pipe, last-grant pointer (points to requester 1, so requester 0 wins the first tie), counters and err_done are all cleared.
- Arbitration: combinational. Only one valid -> grant it. Both valid -> grant the requester that is not last_grant.
  - reqX_ready = grant to X. No backpressure limit: a grant is issued whenever any valid is high.
  - A transfer occurs when valid && ready. Operands may change freely when no transfer occurs.
- Issue stage (registered): on a transfer in cycle t:
  - div_in1/div_in2 <= a/b, div_start <= 1, and last_grant updates.
  - Tag pipe entry 0 <= {valid=1, id}.
  - No transfer -> div_start <= 0 and operands hold their last values.
- Tag pipe:
  - LAT+1 entries, shifted every cycle.
  - The entry written with the issue register becomes the tail entry during the cycle div_out is valid, t+1+LAT.
- Response stage (registered): when the tail entry is valid:
  - rspID_valid <= 1 for one cycle.
  - q/inf/zero <= div_out/div_inf/div_zero.
  - The other rsp valid is 0.
  - Data outputs hold their value when valid is 0.
- Latency: transfer at edge t -> rsp valid during cycle t+LAT+2 (14 cycles default). Throughput is 1 per cycle, and per-requester ordering is preserved.
- Outstanding counters, cnt0/cnt1:
  - Increment on that requester's transfer; decrement on its rsp_valid.
  - Simultaneous increment and decrement -> unchanged.
  - busy = (cnt0 != 0) || (cnt1 != 0).
- Done check: at the tail, if div_done != tail.valid, then err_done <= 1 (sticky until reset). The tag pipe remains authoritative for routing.
- Back-to-back contention: requests alternate 0,1,0,1; neither requester waits more than 1 cycle.
- Reset mid-operation: the tag pipe is cleared and results still inside the divider are discarded (no rsp pulses). Requests present during reset are not accepted.
- Wrap: counters cannot overflow because at most LAT+2 requests are outstanding per requester.

Decomposition:
- Shared package: N, ES, LAT constants; tag struct {valid, id}; requester ID constants REQ0=0, REQ1=1.
- One sub-module: posit_div_tagpipe, a parameterised LAT+1-deep shift register with async reset carrying {valid, id}.
- Arbiter and response mux stay inline.

Test Plan:
- Single request, req0 a=32'h40000000 (1.0), b=32'h40000000 -> req0_ready same cycle; rsp0_valid exactly 14 cycles later with q=32'h40000000, rsp1_valid never asserted.
- Both requesters valid continuously for 20 cycles -> grants alternate 0,1,0,… starting with 0; 10 rsp pulses each, in issue order, each 14 cycles after its grant.
- Only req1 valid for 5 consecutive cycles -> 5 grants to req1; cnt1 peaks at 5; busy deasserts 14 cycles after the last transfer.
- Divider model with div_done forced 0 for one result -> err_done goes and stays 1; rsp still delivered with div_out data.
- Assert rst 6 cycles after issuing 3 requests -> all outputs 0 immediately; no rsp pulses afterward; busy=0.
- Divider returns div_inf=1 for b=0 and div_zero=1 for a=0 -> flags routed to the correct requester's rsp_inf/rsp_zero.
